// File: rtl/decoder_x4_hold_if.sv
// Handshake bundle between a 4x2 priority encoder and the held one-hot decoder.
interface decoder_x4_hold_if;
    logic [1:0] z;
    logic       y;
    logic [3:0] x;
    logic       busy;
    logic       done;

    modport master (output z, y, input x, busy, done);
    modport slave  (input z, y, output x, busy, done);
endinterface

// File: rtl/decoder_x4_hold.sv
// 2-to-4 one-hot decoder that holds each accepted code for HOLD_CYCLES cycles.
// Optional DECODER_X4_DROP_CNT_EN adds drop_cnt, a saturating count of codes dropped while holding.
module decoder_x4_hold #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
`ifdef DECODER_X4_DROP_CNT_EN
    output logic [7:0] drop_cnt,
`endif
    decoder_x4_hold_if.slave bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       x_q, x_nxt;
    logic             done_q, done_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            x_q    <= 4'b0000;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            x_q    <= x_nxt;
            done_q <= done_nxt;
        end
    end

    // done is registered so it lands in the first IDLE cycle, where a new code may be taken.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        x_nxt     = x_q;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                x_nxt = 4'b0000;
                if (bus.y) begin
                    state_nxt = HOLD;
                    cnt_nxt   = CNT_LOAD;
                    x_nxt     = 4'b0001 << bus.z;
                end
            end
            HOLD: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    state_nxt = IDLE;
                    x_nxt     = 4'b0000;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                x_nxt     = 4'b0000;
            end
        endcase
    end

    assign bus.x    = x_q;
    assign bus.busy = (state == HOLD);
    assign bus.done = done_q;

`ifdef DECODER_X4_DROP_CNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            drop_q <= 8'd0;
        else if ((state == HOLD) && bus.y && (drop_q != 8'd255))
            drop_q <= drop_q + 8'd1;
    end

    assign drop_cnt = drop_q;
`endif
endmodule

// File: tb/tb_decoder_x4_hold.sv
// Directed bench for decoder_x4_hold: a HOLD_CYCLES=4 instance and a HOLD_CYCLES=1 instance.
module tb_decoder_x4_hold;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    decoder_x4_hold_if bus4 ();
    decoder_x4_hold_if bus1 ();

`ifdef DECODER_X4_DROP_CNT_EN
    logic [7:0] drop4, drop1;
`endif

    decoder_x4_hold #(.HOLD_CYCLES(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
`ifdef DECODER_X4_DROP_CNT_EN
        .drop_cnt(drop4),
`endif
        .bus(bus4)
    );

    decoder_x4_hold #(.HOLD_CYCLES(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
`ifdef DECODER_X4_DROP_CNT_EN
        .drop_cnt(drop1),
`endif
        .bus(bus1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] ex, input logic eb, input logic ed);
        chk({tag, ".x"},    32'(bus4.x),    32'(ex));
        chk({tag, ".busy"}, 32'(bus4.busy), 32'(eb));
        chk({tag, ".done"}, 32'(bus4.done), 32'(ed));
    endtask

    initial begin
        rst_n = 1'b0;
        bus4.y = 1'b1; bus4.z = 2'b11;
        bus1.y = 1'b0; bus1.z = 2'b00;

        // reset held with a valid code presented
        tick(); chk4("rst0", 4'b0000, 1'b0, 1'b0);
        tick(); chk4("rst1", 4'b0000, 1'b0, 1'b0);
`ifdef DECODER_X4_DROP_CNT_EN
        chk("rst_drop", 32'(drop4), 32'd0);
`endif

        // all-zero encoder input and ignored z while y=0
        rst_n = 1'b1; bus4.y = 1'b0; bus4.z = 2'b00;
        tick(); chk4("idle_zero", 4'b0000, 1'b0, 1'b0);
        bus4.z = 2'b11;
        tick(); chk4("idle_z_ign", 4'b0000, 1'b0, 1'b0);

        // single code z=10
        bus4.y = 1'b1; bus4.z = 2'b10;
        tick(); bus4.y = 1'b0;
        chk4("single_h0", 4'b0100, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) begin
            tick(); chk4($sformatf("single_h%0d", i), 4'b0100, 1'b1, 1'b0);
        end
        tick(); chk4("single_done", 4'b0000, 1'b0, 1'b1);
        tick(); chk4("single_after", 4'b0000, 1'b0, 1'b0);

        // all four codes, each presented after busy falls
        for (int c = 0; c < 4; c++) begin
            bus4.y = 1'b1; bus4.z = 2'(c);
            tick(); bus4.y = 1'b0;
            chk4($sformatf("code%0d_h0", c), 4'(1 << c), 1'b1, 1'b0);
            for (int i = 1; i < 4; i++) begin
                tick(); chk4($sformatf("code%0d_h%0d", c, i), 4'(1 << c), 1'b1, 1'b0);
            end
            tick(); chk4($sformatf("code%0d_done", c), 4'b0000, 1'b0, 1'b1);
        end
        tick(); chk4("codes_after", 4'b0000, 1'b0, 1'b0);

        // drop: new codes during hold are ignored
        bus4.y = 1'b1; bus4.z = 2'b01;
        tick(); chk4("drop_h0", 4'b0010, 1'b1, 1'b0);
        bus4.z = 2'b11;
        for (int i = 1; i < 4; i++) begin
            tick(); chk4($sformatf("drop_h%0d", i), 4'b0010, 1'b1, 1'b0);
        end
        bus4.y = 1'b0;
        tick(); chk4("drop_done", 4'b0000, 1'b0, 1'b1);
`ifdef DECODER_X4_DROP_CNT_EN
        chk("drop_cnt3", 32'(drop4), 32'd3);
`endif
        tick(); chk4("drop_after", 4'b0000, 1'b0, 1'b0);

        // mid-hold reset aborts without done
        bus4.y = 1'b1; bus4.z = 2'b11;
        tick(); bus4.y = 1'b0;
        chk4("mrst_h0", 4'b1000, 1'b1, 1'b0);
        tick(); chk4("mrst_h1", 4'b1000, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick(); chk4("mrst_abort", 4'b0000, 1'b0, 1'b0);
`ifdef DECODER_X4_DROP_CNT_EN
        chk("mrst_drop", 32'(drop4), 32'd0);
`endif
        rst_n = 1'b1;
        tick(); chk4("mrst_nodone0", 4'b0000, 1'b0, 1'b0);
        tick(); chk4("mrst_nodone1", 4'b0000, 1'b0, 1'b0);

        // y=1 during reset is ignored; capture on first released edge
        rst_n = 1'b0; bus4.y = 1'b1; bus4.z = 2'b01;
        tick(); chk4("rsty_ign", 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(); bus4.y = 1'b0;
        chk4("rsty_cap", 4'b0010, 1'b1, 1'b0);
        tick(); tick(); tick();
        chk4("rsty_last", 4'b0010, 1'b1, 1'b0);
        tick(); chk4("rsty_done", 4'b0000, 1'b0, 1'b1);

        // HOLD_CYCLES=1 with y held high: pulse, done+recapture, pulse...
        bus1.y = 1'b1; bus1.z = 2'b00;
        for (int r = 0; r < 3; r++) begin
            tick();
            chk($sformatf("h1_x_on%0d", r),    32'(bus1.x),    32'h1);
            chk($sformatf("h1_busy_on%0d", r), 32'(bus1.busy), 32'h1);
            chk($sformatf("h1_done_on%0d", r), 32'(bus1.done), 32'h0);
            tick();
            chk($sformatf("h1_x_off%0d", r),    32'(bus1.x),    32'h0);
            chk($sformatf("h1_busy_off%0d", r), 32'(bus1.busy), 32'h0);
            chk($sformatf("h1_done_off%0d", r), 32'(bus1.done), 32'h1);
        end
        bus1.y = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
